// File: rtl/store_narrow_unit.sv
// Store path for SB/SH/SW into word-organised data memory.
// Sub-word stores read the target word, merge the new lanes and write it back.
module store_narrow_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        mem_wr_en,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_WAIT_RD = 3'd2;
   localparam logic [2:0] S_WR      = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [1:0] OP_SB = 2'b00;
   localparam logic [1:0] OP_SH = 2'b01;
   localparam logic [1:0] OP_SW = 2'b10;

   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   logic [2:0]  state_reg;
   logic [1:0]  op_reg;
   logic [1:0]  lane_reg;
   logic [15:0] wdata_lo_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] cnt_reg;
   logic        err_reg;

   logic        bad_req;
   logic        timeout_hit;
   logic [31:0] merged;

   assign bad_req = (op == 2'b11) ||
                    ((op == OP_SH) && addr[0]) ||
                    ((op == OP_SW) && (addr[1:0] != 2'b00));

   // Fires on the waiting cycle that would bring the counter up to the limit.
   assign timeout_hit = (TIMEOUT_LIMIT != 32'd0) && ((cnt_reg + 32'd1) == TIMEOUT_LIMIT);

   // Little-endian lane merge of the new byte/halfword into the word read back.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       sel;
         logic [7:0] new_byte;
         always_comb begin
            sel      = 1'b0;
            new_byte = wdata_lo_reg[7:0];
            if (op_reg == OP_SB) begin
               sel = (lane_reg == LANE);
            end else begin
               sel      = (lane_reg[1] == LANE[1]);
               new_byte = LANE[0] ? wdata_lo_reg[15:8] : wdata_lo_reg[7:0];
            end
         end
         assign merged[8*gi +: 8] = sel ? new_byte : mem_rdata[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         op_reg       <= 2'b00;
         lane_reg     <= 2'b00;
         wdata_lo_reg <= 16'd0;
         addr_reg     <= 32'd0;
         wdata_reg    <= 32'd0;
         cnt_reg      <= 32'd0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  op_reg       <= op;
                  lane_reg     <= addr[1:0];
                  wdata_lo_reg <= wdata[15:0];
                  addr_reg     <= {addr[31:2], 2'b00};
                  cnt_reg      <= 32'd0;
                  err_reg      <= bad_req;
                  if (bad_req) begin
                     state_reg <= S_DONE;
                  end else if (op == OP_SW) begin
                     wdata_reg <= wdata;
                     state_reg <= S_WR;
                  end else begin
                     state_reg <= S_RD;
                  end
               end
            end
            S_RD: begin
               cnt_reg   <= 32'd0;
               state_reg <= S_WAIT_RD;
            end
            S_WAIT_RD: begin
               if (mem_rvalid) begin
                  wdata_reg <= merged;
                  cnt_reg   <= 32'd0;
                  state_reg <= S_WR;
               end else if (timeout_hit) begin
                  err_reg   <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            S_WR: begin
               if (mem_ready) begin
                  state_reg <= S_DONE;
               end else if (timeout_hit) begin
                  err_reg   <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // Handshake outputs decode straight from state so reset removes them at once.
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign mem_rd_en = (state_reg == S_RD);
   assign mem_wr_en = (state_reg == S_WR);
   assign busy      = (state_reg == S_RD) || (state_reg == S_WAIT_RD) || (state_reg == S_WR);
   assign done      = (state_reg == S_DONE);
   assign err       = done && err_reg;

endmodule
